// File: rtl/rom_fetch_unit.sv
// rom_fetch_unit: drives word addresses into a combinational instruction ROM and buffers
// each returned word together with its PC in a prefetch FIFO that decode drains over valid/ready.
module rom_fetch_unit #(
    parameter int                    ADDR_WIDTH = 32,
    parameter int                    DATA_WIDTH = 32,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0,
    parameter int                    FIFO_DEPTH = 4
) (
    input  logic                          clk_i,
    input  logic                          rst_ni,
    input  logic                          fetch_en_i,
    output logic [ADDR_WIDTH-1:0]         rom_addr_o,
    input  logic [DATA_WIDTH-1:0]         rom_data_i,
    input  logic                          redirect_valid_i,
    input  logic [ADDR_WIDTH-1:0]         redirect_pc_i,
    output logic                          instr_valid_o,
    output logic [DATA_WIDTH-1:0]         instr_o,
    output logic [ADDR_WIDTH-1:0]         instr_pc_o,
    input  logic                          instr_ready_i,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count_o
);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;
    localparam logic [ADDR_WIDTH-1:0] ALIGN = ~ADDR_WIDTH'(3);

    logic [ADDR_WIDTH-1:0] pc_q, pc_d;
    logic [CW-1:0]         count_q, count_d;
    logic [PW-1:0]         rd_q, wr_q;
    logic [DATA_WIDTH-1:0] data_q [FIFO_DEPTH];
    logic [ADDR_WIDTH-1:0] epc_q  [FIFO_DEPTH];
    logic                  push, pop;

    // A pop frees a slot in the same edge, so a full FIFO can still accept a push
    always_comb begin
        pop     = instr_valid_o & instr_ready_i;
        push    = fetch_en_i & ~redirect_valid_i & ((count_q < CW'(FIFO_DEPTH)) | pop);
        count_d = count_q + CW'(push) - CW'(pop);
        pc_d    = push ? pc_q + ADDR_WIDTH'(4) : pc_q;
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            pc_q    <= RESET_PC & ALIGN;
            count_q <= '0;
            rd_q    <= '0;
            wr_q    <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                data_q[i] <= '0;
                epc_q[i]  <= '0;
            end
        end else if (redirect_valid_i) begin
            pc_q    <= redirect_pc_i & ALIGN;
            count_q <= '0;
            rd_q    <= '0;
            wr_q    <= '0;
        end else begin
            if (push) begin
                data_q[wr_q] <= rom_data_i;
                epc_q[wr_q]  <= pc_q;
                wr_q         <= wr_q + PW'(1);
            end
            if (pop) rd_q <= rd_q + PW'(1);
            pc_q    <= pc_d;
            count_q <= count_d;
        end
    end

    assign rom_addr_o    = pc_q >> 2;
    assign instr_valid_o = count_q != '0;
    assign instr_o       = data_q[rd_q];
    assign instr_pc_o    = epc_q[rd_q];
    assign fifo_count_o  = count_q;
endmodule

// File: tb/tb_rom_fetch_unit.sv
// tb_rom_fetch_unit: directed scenarios for the prefetch unit against a ROM holding ROM[i] = i*0x11.
module tb_rom_fetch_unit;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        fetch_en = 1'b0;
    logic [31:0] rom_addr;
    logic [31:0] rom_data;
    logic        redir = 1'b0;
    logic [31:0] redir_pc = '0;
    logic        valid;
    logic [31:0] instr;
    logic [31:0] ipc;
    logic        ready = 1'b0;
    logic [2:0]  count;
    int          n_cmp = 0;
    int          n_fail = 0;

    always #5 clk = ~clk;

    assign rom_data = rom_addr * 32'h11;

    rom_fetch_unit #(.RESET_PC(32'h100)) dut (
        .clk_i(clk), .rst_ni(rst_n), .fetch_en_i(fetch_en), .rom_addr_o(rom_addr),
        .rom_data_i(rom_data), .redirect_valid_i(redir), .redirect_pc_i(redir_pc),
        .instr_valid_o(valid), .instr_o(instr), .instr_pc_o(ipc),
        .instr_ready_i(ready), .fifo_count_o(count)
    );

    task automatic test_reset();
        @(negedge clk);
        @(negedge clk);
        n_cmp++; if (valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b exp 0", valid); end
        n_cmp++; if (instr !== 32'h0) begin n_fail++; $display("FAIL reset_instr: got %h exp 0", instr); end
        n_cmp++; if (ipc !== 32'h0) begin n_fail++; $display("FAIL reset_pc: got %h exp 0", ipc); end
        n_cmp++; if (count !== 3'd0) begin n_fail++; $display("FAIL reset_count: got %0d exp 0", count); end
        n_cmp++; if (rom_addr !== 32'h40) begin n_fail++; $display("FAIL reset_addr: got %h exp 40", rom_addr); end
    endtask

    task automatic test_stream();
        logic [31:0] epc, ein;
        rst_n = 1'b1; fetch_en = 1'b1; ready = 1'b1;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            epc = 32'h100 + 32'(4 * k);
            ein = (32'h40 + 32'(k)) * 32'h11;
            n_cmp++; if (valid !== 1'b1) begin n_fail++; $display("FAIL stream_valid[%0d]: got %b exp 1", k, valid); end
            n_cmp++; if (ipc !== epc) begin n_fail++; $display("FAIL stream_pc[%0d]: got %h exp %h", k, ipc, epc); end
            n_cmp++; if (instr !== ein) begin n_fail++; $display("FAIL stream_instr[%0d]: got %h exp %h", k, instr, ein); end
        end
    endtask

    task automatic test_backpressure();
        rst_n = 1'b0; ready = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (6) @(negedge clk);
        n_cmp++; if (count !== 3'd4) begin n_fail++; $display("FAIL bp_count6: got %0d exp 4", count); end
        n_cmp++; if (rom_addr !== 32'h44) begin n_fail++; $display("FAIL bp_addr6: got %h exp 44", rom_addr); end
        repeat (2) @(negedge clk);
        n_cmp++; if (count !== 3'd4) begin n_fail++; $display("FAIL bp_count8: got %0d exp 4", count); end
        n_cmp++; if (rom_addr !== 32'h44) begin n_fail++; $display("FAIL bp_addr8: got %h exp 44", rom_addr); end
        n_cmp++; if (ipc !== 32'h100) begin n_fail++; $display("FAIL bp_head_pc: got %h exp 100", ipc); end
        n_cmp++; if (instr !== 32'h440) begin n_fail++; $display("FAIL bp_head_instr: got %h exp 440", instr); end
        ready = 1'b1;
    endtask

    task automatic test_full_pushpop();
        @(negedge clk);
        n_cmp++; if (count !== 3'd4) begin n_fail++; $display("FAIL full_pp_count: got %0d exp 4", count); end
        n_cmp++; if (ipc !== 32'h104) begin n_fail++; $display("FAIL full_pp_pc: got %h exp 104", ipc); end
        n_cmp++; if (instr !== 32'h451) begin n_fail++; $display("FAIL full_pp_instr: got %h exp 451", instr); end
    endtask

    task automatic test_drain_order();
        logic [31:0] epc;
        for (int k = 2; k < 6; k++) begin
            @(negedge clk);
            epc = 32'h100 + 32'(4 * k);
            n_cmp++; if (ipc !== epc) begin n_fail++; $display("FAIL drain_pc[%0d]: got %h exp %h", k, ipc, epc); end
            n_cmp++; if (count !== 3'd4) begin n_fail++; $display("FAIL drain_count[%0d]: got %0d exp 4", k, count); end
        end
    endtask

    task automatic test_redirect();
        fetch_en = 1'b0;
        @(negedge clk);
        n_cmp++; if (count !== 3'd3) begin n_fail++; $display("FAIL redir_pre_count: got %0d exp 3", count); end
        n_cmp++; if (ipc !== 32'h118) begin n_fail++; $display("FAIL redir_pre_pc: got %h exp 118", ipc); end
        fetch_en = 1'b1; redir = 1'b1; redir_pc = 32'h2002;
        @(negedge clk);
        redir = 1'b0;
        n_cmp++; if (valid !== 1'b0) begin n_fail++; $display("FAIL redir_valid: got %b exp 0", valid); end
        n_cmp++; if (count !== 3'd0) begin n_fail++; $display("FAIL redir_count: got %0d exp 0", count); end
        n_cmp++; if (rom_addr !== 32'h800) begin n_fail++; $display("FAIL redir_addr: got %h exp 800", rom_addr); end
        @(negedge clk);
        n_cmp++; if (valid !== 1'b1) begin n_fail++; $display("FAIL redir_next_valid: got %b exp 1", valid); end
        n_cmp++; if (ipc !== 32'h2000) begin n_fail++; $display("FAIL redir_next_pc: got %h exp 2000", ipc); end
        n_cmp++; if (instr !== 32'h8800) begin n_fail++; $display("FAIL redir_next_instr: got %h exp 8800", instr); end
    endtask

    task automatic test_back_to_back();
        redir = 1'b1; redir_pc = 32'h3000;
        @(negedge clk);
        redir_pc = 32'h4004;
        @(negedge clk);
        redir = 1'b0;
        n_cmp++; if (valid !== 1'b0) begin n_fail++; $display("FAIL b2b_valid: got %b exp 0", valid); end
        n_cmp++; if (rom_addr !== 32'h1001) begin n_fail++; $display("FAIL b2b_addr: got %h exp 1001", rom_addr); end
        @(negedge clk);
        n_cmp++; if (ipc !== 32'h4004) begin n_fail++; $display("FAIL b2b_pc: got %h exp 4004", ipc); end
        n_cmp++; if (instr !== 32'h11011) begin n_fail++; $display("FAIL b2b_instr: got %h exp 11011", instr); end
    endtask

    task automatic test_pc_wrap();
        logic [31:0] epc [3];
        logic [31:0] ein [3];
        epc = '{32'hFFFF_FFF8, 32'hFFFF_FFFC, 32'h0000_0000};
        ein = '{32'h3FFF_FFDE, 32'h3FFF_FFEF, 32'h0000_0000};
        redir = 1'b1; redir_pc = 32'hFFFF_FFF8;
        @(negedge clk);
        redir = 1'b0;
        n_cmp++; if (rom_addr !== 32'h3FFF_FFFE) begin n_fail++; $display("FAIL wrap_addr: got %h exp 3ffffffe", rom_addr); end
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            n_cmp++; if (ipc !== epc[k]) begin n_fail++; $display("FAIL wrap_pc[%0d]: got %h exp %h", k, ipc, epc[k]); end
            n_cmp++; if (instr !== ein[k]) begin n_fail++; $display("FAIL wrap_instr[%0d]: got %h exp %h", k, instr, ein[k]); end
        end
    endtask

    task automatic test_fetch_disable();
        fetch_en = 1'b0;
        @(negedge clk);
        n_cmp++; if (valid !== 1'b0) begin n_fail++; $display("FAIL dis_valid: got %b exp 0", valid); end
        n_cmp++; if (rom_addr !== 32'h1) begin n_fail++; $display("FAIL dis_addr: got %h exp 1", rom_addr); end
        @(negedge clk);
        n_cmp++; if (rom_addr !== 32'h1) begin n_fail++; $display("FAIL dis_addr_hold: got %h exp 1", rom_addr); end
        n_cmp++; if (count !== 3'd0) begin n_fail++; $display("FAIL dis_count: got %0d exp 0", count); end
    endtask

    task automatic test_reset_mid();
        fetch_en = 1'b1; ready = 1'b0;
        repeat (5) @(negedge clk);
        n_cmp++; if (count !== 3'd4) begin n_fail++; $display("FAIL rmid_full: got %0d exp 4", count); end
        rst_n = 1'b0; redir = 1'b1; redir_pc = 32'h5000;
        @(negedge clk);
        rst_n = 1'b1; redir = 1'b0; ready = 1'b1;
        n_cmp++; if (valid !== 1'b0) begin n_fail++; $display("FAIL rmid_valid: got %b exp 0", valid); end
        n_cmp++; if (instr !== 32'h0) begin n_fail++; $display("FAIL rmid_instr: got %h exp 0", instr); end
        n_cmp++; if (ipc !== 32'h0) begin n_fail++; $display("FAIL rmid_pc: got %h exp 0", ipc); end
        n_cmp++; if (count !== 3'd0) begin n_fail++; $display("FAIL rmid_count: got %0d exp 0", count); end
        n_cmp++; if (rom_addr !== 32'h40) begin n_fail++; $display("FAIL rmid_addr: got %h exp 40", rom_addr); end
        @(negedge clk);
        n_cmp++; if (ipc !== 32'h100) begin n_fail++; $display("FAIL rmid_resume0: got %h exp 100", ipc); end
        @(negedge clk);
        n_cmp++; if (ipc !== 32'h104) begin n_fail++; $display("FAIL rmid_resume1: got %h exp 104", ipc); end
        n_cmp++; if (instr !== 32'h451) begin n_fail++; $display("FAIL rmid_resume_instr: got %h exp 451", instr); end
    endtask

    initial begin
        test_reset();
        test_stream();
        test_backpressure();
        test_full_pushpop();
        test_drain_order();
        test_redirect();
        test_back_to_back();
        test_pc_wrap();
        test_fetch_disable();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
